// File: rtl/core_bus_arbiter_if.sv
// Naive bus bundle: level-held read/write requests, same-cycle grants,
// read data one cycle after the read grant.
interface core_bus_arbiter_if;
  logic        rd_req;
  logic        rd_gnt;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;
  logic        wr_req;
  logic        wr_gnt;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
    input  rd_gnt, rd_data, wr_gnt
  );

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
    output rd_gnt, rd_data, wr_gnt
  );
endinterface

// File: rtl/core_bus_arbiter.sv
// Merges instruction (read-only) and data (read/write) masters onto one slave
// port; combinational request path, registered read-data routing, fetch starvation guard.
module core_bus_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic              clk,
  input logic              rst,
  core_bus_arbiter_if.slave  ibus,
  core_bus_arbiter_if.slave  dbus,
  core_bus_arbiter_if.master sbus
);

  localparam logic [3:0] LIMIT = STARVE_LIMIT[3:0];

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("core_bus_arbiter: STARVE_LIMIT must be within 1..15");
  end

  typedef enum logic [1:0] {OWN_NONE, OWN_IR, OWN_DR, OWN_DW} owner_t;
  typedef enum logic       {IDLE, HOLD}                       state_t;
  typedef enum logic [1:0] {RSP_NONE, RSP_I, RSP_D}           rsp_t;

  state_t      state, state_next;
  owner_t      hold_owner, hold_owner_next;
  owner_t      pick, sel;
  logic        hold_live;
  logic        sel_gnt;
  logic        ir, dr, dw;
  logic [3:0]  starve_cnt;
  rsp_t        rsp_owner_p1;
  logic [31:0] i_hold_p1;
  logic [31:0] d_hold_p1;

  // The instruction master never writes; its write side is intentionally ignored.
  logic unused_ibus_wr;
  assign unused_ibus_wr = ^{ibus.wr_req, ibus.wr_addr, ibus.wr_data, ibus.wr_be};

  function automatic logic owner_req(owner_t o, logic r_i, logic r_d, logic w_d);
    case (o)
      OWN_IR:  return r_i;
      OWN_DR:  return r_d;
      OWN_DW:  return w_d;
      default: return 1'b0;
    endcase
  endfunction

  // Saturating counter of consecutive ungranted fetch cycles; a grant clears it.
  function automatic logic [3:0] starve_step(logic [3:0] cnt, logic req, logic gnt);
    if (!req || gnt)
      return 4'd0;
    else if (cnt >= LIMIT)
      return LIMIT;
    else
      return 4'(cnt + 4'd1);
  endfunction

  assign ir = ibus.rd_req;
  assign dr = dbus.rd_req;
  assign dw = dbus.wr_req;

  always_comb begin
    pick = OWN_NONE;
    if (ir && (starve_cnt == LIMIT))
      pick = OWN_IR;
    else if (dw)
      pick = OWN_DW;
    else if (dr)
      pick = OWN_DR;
    else if (ir)
      pick = OWN_IR;
  end

  // A locked owner that has dropped its request releases the lock in the same cycle.
  assign hold_live = (state == HOLD) && owner_req(hold_owner, ir, dr, dw);
  assign sel       = hold_live ? hold_owner : pick;

  always_comb begin
    sel_gnt = 1'b0;
    case (sel)
      OWN_IR, OWN_DR: sel_gnt = sbus.rd_gnt;
      OWN_DW:         sel_gnt = sbus.wr_gnt;
      default:        sel_gnt = 1'b0;
    endcase
  end

  always_comb begin
    state_next      = IDLE;
    hold_owner_next = hold_owner;
    if ((sel != OWN_NONE) && !sel_gnt) begin
      state_next      = HOLD;
      hold_owner_next = sel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      hold_owner <= OWN_NONE;
      starve_cnt <= 4'd0;
    end else begin
      state      <= state_next;
      hold_owner <= hold_owner_next;
      starve_cnt <= starve_step(starve_cnt, ir, ibus.rd_gnt);
    end
  end

  assign sbus.rd_req  = (sel == OWN_IR) || (sel == OWN_DR);
  assign sbus.rd_addr = (sel == OWN_IR) ? ibus.rd_addr : dbus.rd_addr;
  assign sbus.wr_req  = (sel == OWN_DW);
  assign sbus.wr_addr = dbus.wr_addr;
  assign sbus.wr_data = dbus.wr_data;
  assign sbus.wr_be   = dbus.wr_be;

  assign ibus.rd_gnt = (sel == OWN_IR) && sbus.rd_gnt;
  assign dbus.rd_gnt = (sel == OWN_DR) && sbus.rd_gnt;
  assign dbus.wr_gnt = (sel == OWN_DW) && sbus.wr_gnt;
  assign ibus.wr_gnt = 1'b0;

  // ---- p1: response owner and per-master hold of last delivered read data ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_owner_p1 <= RSP_NONE;
      i_hold_p1    <= 32'd0;
      d_hold_p1    <= 32'd0;
    end else begin
      if (ibus.rd_gnt)
        rsp_owner_p1 <= RSP_I;
      else if (dbus.rd_gnt)
        rsp_owner_p1 <= RSP_D;
      else
        rsp_owner_p1 <= RSP_NONE;
      if (rsp_owner_p1 == RSP_I)
        i_hold_p1 <= sbus.rd_data;
      if (rsp_owner_p1 == RSP_D)
        d_hold_p1 <= sbus.rd_data;
    end
  end

  assign ibus.rd_data = (rsp_owner_p1 == RSP_I) ? sbus.rd_data : i_hold_p1;
  assign dbus.rd_data = (rsp_owner_p1 == RSP_D) ? sbus.rd_data : d_hold_p1;

`ifndef SYNTHESIS
  a_one_req: assert property (@(posedge clk) disable iff (rst)
    !(sbus.rd_req && sbus.wr_req));
  a_one_gnt: assert property (@(posedge clk) disable iff (rst)
    $onehot0({ibus.rd_gnt, dbus.rd_gnt, dbus.wr_gnt}));
  a_cnt_sat: assert property (@(posedge clk) disable iff (rst)
    starve_cnt <= LIMIT);
`endif

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Directed bench for core_bus_arbiter: stimulus pushes expected grants and read
// responses into queues; a negedge monitor pops and compares them.
module tb_core_bus_arbiter;

  logic clk;
  logic rst;

  core_bus_arbiter_if ibus ();
  core_bus_arbiter_if dbus ();
  core_bus_arbiter_if sbus ();

  core_bus_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .ibus (ibus),
    .dbus (dbus),
    .sbus (sbus)
  );

  typedef struct {
    logic [2:0]  gnt;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } gexp_t;

  typedef struct {
    logic        side_i;
    logic [31:0] data;
  } rexp_t;

  gexp_t exp_q[$];
  rexp_t rd_q[$];

  int n_checks = 0;
  int n_err    = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic push_g(input logic [2:0] g, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be);
    gexp_t e;
    e.gnt = g; e.addr = a; e.wdata = wd; e.be = be;
    exp_q.push_back(e);
  endtask

  task automatic push_r(input logic side_i, input logic [31:0] d);
    rexp_t e;
    e.side_i = side_i; e.data = d;
    rd_q.push_back(e);
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia,
                       input logic dr, input logic [31:0] da,
                       input logic dw, input logic [31:0] wa,
                       input logic [31:0] wd, input logic [3:0] be,
                       input logic rg, input logic wg, input logic [31:0] rdat);
    ibus.rd_req  = ir;  ibus.rd_addr = ia;
    ibus.wr_req  = 1'b0; ibus.wr_addr = '0; ibus.wr_data = '0; ibus.wr_be = '0;
    dbus.rd_req  = dr;  dbus.rd_addr = da;
    dbus.wr_req  = dw;  dbus.wr_addr = wa; dbus.wr_data = wd; dbus.wr_be = be;
    sbus.rd_gnt  = rg;  sbus.wr_gnt  = wg; sbus.rd_data = rdat;
  endtask

  // Monitor: compares every presented grant and every read-data cycle.
  initial begin
    logic        pend;
    logic [31:0] i_last, d_last;
    logic [2:0]  gv;
    gexp_t       g;
    rexp_t       r;
    pend = 1'b0; i_last = '0; d_last = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend = 1'b0; i_last = '0; d_last = '0;
      end else if (pend) begin
        if (rd_q.size() == 0) chk("rd_q_empty", rd_q.size(), 1);
        else begin
          r = rd_q.pop_front();
          if (r.side_i) i_last = r.data;
          else          d_last = r.data;
        end
      end
      chk("i_rd_data", ibus.rd_data, i_last);
      chk("d_rd_data", dbus.rd_data, d_last);
      gv = {ibus.rd_gnt, dbus.rd_gnt, dbus.wr_gnt};
      pend = 1'b0;
      if (!rst && gv != 3'b000) begin
        if (exp_q.size() == 0) chk("gnt_unexpected", 32'(gv), 0);
        else begin
          g = exp_q.pop_front();
          chk("gnt_vec", 32'(gv), 32'(g.gnt));
          if (gv[0]) begin
            chk("s_wr_addr", sbus.wr_addr, g.addr);
            chk("s_wr_data", sbus.wr_data, g.wdata);
            chk("s_wr_be", 32'(sbus.wr_be), 32'(g.be));
          end else begin
            chk("s_rd_addr", sbus.rd_addr, g.addr);
          end
        end
        pend = gv[2] | gv[1];
      end
    end
  end

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    tick; tick;
    chk("rst_s_rd_req", sbus.rd_req, 0);
    chk("rst_s_wr_req", sbus.wr_req, 0);
    chk("rst_i_gnt", ibus.rd_gnt, 0);
    chk("rst_d_rd_gnt", dbus.rd_gnt, 0);
    chk("rst_d_wr_gnt", dbus.wr_gnt, 0);
    chk("rst_i_rd_data", ibus.rd_data, 0);
    chk("rst_d_rd_data", dbus.rd_data, 0);
    rst = 1'b0;
    tick;
    chk("idle_gnts", {ibus.rd_gnt, dbus.rd_gnt, dbus.wr_gnt}, 0);

    // Single instruction read
    drive(1, 32'h100, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    push_g(3'b100, 32'h100, 0, 0); push_r(1, 32'h13);
    tick;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h13);
    tick;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h99);
    settle;
    chk("t1_i_hold", ibus.rd_data, 32'h13);
    tick;

    // Contention: data wins four cycles, then fetch once, then data again
    for (int k = 0; k < 6; k++) begin
      drive(1, 32'h200, 1, 32'h300, 0, 0, 0, 0, 1, 0, 32'h1000 + k);
      if (k == 4) begin push_g(3'b100, 32'h200, 0, 0); push_r(1, 32'h1001 + k); end
      else        begin push_g(3'b010, 32'h300, 0, 0); push_r(0, 32'h1001 + k); end
      tick;
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1006);
    tick;

    // Hold lock on a stalled write while fetch rises
    drive(0, 0, 0, 0, 1, 32'h400, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    settle;
    chk("t3_c0_wr_req", sbus.wr_req, 1);
    chk("t3_c0_wr_addr", sbus.wr_addr, 32'h400);
    tick;
    for (int k = 1; k < 3; k++) begin
      drive(1, 32'h500, 0, 0, 1, 32'h400, 32'hDEADBEEF, 4'hF, 1, 0, 0);
      settle;
      chk("t3_wr_req", sbus.wr_req, 1);
      chk("t3_wr_addr", sbus.wr_addr, 32'h400);
      chk("t3_rd_req", sbus.rd_req, 0);
      chk("t3_i_gnt", ibus.rd_gnt, 0);
      tick;
    end
    drive(1, 32'h500, 0, 0, 1, 32'h400, 32'hDEADBEEF, 4'hF, 0, 1, 0);
    push_g(3'b001, 32'h400, 32'hDEADBEEF, 4'hF);
    tick;
    drive(1, 32'h500, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    push_g(3'b100, 32'h500, 0, 0); push_r(1, 32'h77);
    tick;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h77);
    tick;

    // Hold keeps a stalled fetch ahead of a later data read
    drive(1, 32'h600, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick;
    drive(1, 32'h600, 1, 32'h700, 0, 0, 0, 0, 0, 0, 0);
    settle;
    chk("t4_rd_addr_held", sbus.rd_addr, 32'h600);
    tick;
    drive(1, 32'h600, 1, 32'h700, 0, 0, 0, 0, 1, 0, 0);
    push_g(3'b100, 32'h600, 0, 0); push_r(1, 32'h66);
    tick;
    drive(0, 0, 1, 32'h700, 0, 0, 0, 0, 1, 0, 32'h66);
    push_g(3'b010, 32'h700, 0, 0); push_r(0, 32'h67);
    tick;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h67);
    tick;

    // Held owner drops its request; write granted in the same cycle
    drive(1, 32'h800, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick;
    drive(0, 0, 0, 0, 1, 32'h900, 32'h12345678, 4'h3, 0, 1, 0);
    push_g(3'b001, 32'h900, 32'h12345678, 4'h3);
    tick;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick;

    // Response routing: data read then fetch read back to back
    drive(0, 0, 1, 32'hA00, 0, 0, 0, 0, 1, 0, 0);
    push_g(3'b010, 32'hA00, 0, 0); push_r(0, 32'hAAAA);
    tick;
    drive(1, 32'hB00, 0, 0, 0, 0, 0, 0, 1, 0, 32'hAAAA);
    push_g(3'b100, 32'hB00, 0, 0); push_r(1, 32'h5555);
    tick;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h5555);
    tick;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF);
    settle;
    chk("t6_d_keep", dbus.rd_data, 32'hAAAA);
    chk("t6_i_keep", ibus.rd_data, 32'h5555);
    tick;

    // Read/write collision: write is the data candidate
    drive(0, 0, 1, 32'hC00, 1, 32'hD00, 32'hCAFE, 4'hF, 1, 1, 0);
    settle;
    chk("t7_s_wr_req", sbus.wr_req, 1);
    chk("t7_s_rd_req", sbus.rd_req, 0);
    chk("t7_d_wr_gnt", dbus.wr_gnt, 1);
    chk("t7_d_rd_gnt", dbus.rd_gnt, 0);
    push_g(3'b001, 32'hD00, 32'hCAFE, 4'hF);
    tick;
    drive(0, 0, 1, 32'hC00, 0, 0, 0, 0, 1, 0, 0);
    push_g(3'b010, 32'hC00, 0, 0); push_r(0, 32'hC0C0);
    tick;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hC0C0);
    tick;

    // Reset while a granted read is in flight: nothing delivered
    drive(0, 0, 1, 32'hE00, 0, 0, 0, 0, 1, 0, 0);
    push_g(3'b010, 32'hE00, 0, 0);
    tick;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hBAD);
    settle;
    chk("t8_d_rd_data", dbus.rd_data, 0);
    chk("t8_i_rd_data", ibus.rd_data, 0);
    tick;
    rst = 1'b0;
    tick; tick;
    chk("t8_d_after", dbus.rd_data, 0);

    chk("exp_q_drained", exp_q.size(), 0);
    chk("rd_q_drained", rd_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
